icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 96 +++++++++
 tb/tb_icache.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache keyed by halfword address, with a single
// outstanding refill that survives pipeline flushes (the fill is still written).
module icache #(
  parameter int ICACHE_IDX_WIDTH = 6,
  parameter int XLEN             = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fet_icache_enable,
  input  logic [XLEN-1:0] fet_pc,
  output logic            icache_ready,
  output logic [XLEN-1:0] icache_inst,
  output logic            ic_mem_req,
  output logic [XLEN-1:0] ic_mem_addr,
  input  logic            mc_inst_ready,
  input  logic [XLEN-1:0] mc_inst,
  output logic            ic_fill_ready,
  output logic [XLEN-1:0] ic_fill_inst
);
  localparam int ENTRIES = 1 << ICACHE_IDX_WIDTH;
  localparam int TAG_W   = XLEN - ICACHE_IDX_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } line_t;

  state_t                      state, state_nxt;
  logic [ENTRIES-1:0]          valid;
  line_t                       lines [ENTRIES];
  logic [ICACHE_IDX_WIDTH-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]            rd_tag, wr_tag;
  logic                        lookup, tag_hit, miss, fill_wr;
  logic                        unused_bits;

  // Bit 0 of a halfword-aligned address carries no information.
  assign unused_bits = ^{fet_pc[0], ic_mem_addr[0]};

  assign rd_idx = fet_pc[ICACHE_IDX_WIDTH:1];
  assign rd_tag = fet_pc[XLEN-1:ICACHE_IDX_WIDTH+1];
  assign wr_idx = ic_mem_addr[ICACHE_IDX_WIDTH:1];
  assign wr_tag = ic_mem_addr[XLEN-1:ICACHE_IDX_WIDTH+1];

  assign lookup  = (state == IDLE) & rdy & fet_icache_enable & ~flush;
  assign tag_hit = valid[rd_idx] & (lines[rd_idx].tag == rd_tag);
  assign miss    = lookup & ~tag_hit;

  assign icache_ready = lookup & tag_hit;
  assign icache_inst  = lines[rd_idx].data;

  // Any response while a request is outstanding is written, even if the
  // fetcher no longer wants it, so a retried fetch hits.
  assign fill_wr       = rdy & mc_inst_ready & (state != IDLE);
  assign ic_fill_ready = rdy & mc_inst_ready & ~flush & (state == WAIT);
  assign ic_fill_inst  = mc_inst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss) state_nxt = WAIT;
      WAIT: begin
        if (mc_inst_ready)  state_nxt = IDLE;
        else if (flush)     state_nxt = DRAIN;
      end
      DRAIN:   if (mc_inst_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      valid       <= '0;
      ic_mem_req  <= 1'b0;
      ic_mem_addr <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      if (miss) begin
        ic_mem_req  <= 1'b1;
        ic_mem_addr <= fet_pc;
      end else if (fill_wr) begin
        ic_mem_req  <= 1'b0;
      end
      if (fill_wr) valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (fill_wr) lines[wr_idx] <= '{tag: wr_tag, data: mc_inst};
  end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then random
// traffic checked every cycle against an address-level cache/refill model.
module tb_icache;
  localparam int IDX = 6;

  logic        clk = 0, rst = 0, rdy = 0, flush = 0, en = 0, mc_rdy = 0;
  logic [31:0] pc = 0, mc_inst = 0;
  logic        icache_ready, ic_mem_req, ic_fill_ready;
  logic [31:0] icache_inst, ic_mem_addr, ic_fill_inst;

  icache #(.ICACHE_IDX_WIDTH(IDX), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fet_icache_enable(en), .fet_pc(pc),
    .icache_ready(icache_ready), .icache_inst(icache_inst),
    .ic_mem_req(ic_mem_req), .ic_mem_addr(ic_mem_addr),
    .mc_inst_ready(mc_rdy), .mc_inst(mc_inst),
    .ic_fill_ready(ic_fill_ready), .ic_fill_inst(ic_fill_inst)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: which halfword address each slot holds, the data per address,
  // and whether a refill is outstanding / was flushed.
  logic [31:0] owner [int];
  logic [31:0] mdata [logic [31:0]];
  bit          busy, dropped;
  logic [31:0] maddr;
  bit          e_hit, e_fill;

  function automatic int ix(input logic [31:0] a);
    return int'(a[IDX:1]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    owner.delete();
    busy = 0; dropped = 0; maddr = 0;
  endtask

  always @(negedge rst) mreset();

  always @(negedge clk) begin
    if (!rst) mreset();
    e_hit  = !busy && rdy && en && !flush && owner.exists(ix(pc)) && owner[ix(pc)] == pc;
    e_fill = busy && !dropped && rdy && mc_rdy && !flush;
    chk("m_icache_ready", {31'b0, icache_ready}, {31'b0, e_hit});
    if (e_hit) chk("m_icache_inst", icache_inst, mdata[pc]);
    chk("m_ic_mem_req", {31'b0, ic_mem_req}, {31'b0, busy});
    chk("m_ic_mem_addr", ic_mem_addr, maddr);
    chk("m_ic_fill_ready", {31'b0, ic_fill_ready}, {31'b0, e_fill});
    if (e_fill) chk("m_ic_fill_inst", ic_fill_inst, mc_inst);
    if (rst && rdy) begin
      if (!busy) begin
        if (en && !flush && !e_hit) begin busy = 1; dropped = 0; maddr = pc; end
      end else if (mc_rdy) begin
        owner[ix(maddr)] = maddr;
        mdata[maddr] = mc_inst;
        busy = 0;
      end else if (flush) begin
        dropped = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    en = 1; pc = a; tick();
    en = 0; mc_rdy = 1; mc_inst = d; tick();
    mc_rdy = 0;
  endtask

  initial begin
    rdy = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", {31'b0, ic_mem_req}, 0);
    chk("rst_addr", ic_mem_addr, 0);
    chk("rst_ready", {31'b0, icache_ready}, 0);
    chk("rst_fill", {31'b0, ic_fill_ready}, 0);
    tick(); rst = 1;

    // cold miss
    en = 1; pc = 32'h0;
    @(negedge clk); chk("cold_miss", {31'b0, icache_ready}, 0);
    tick(); en = 0;
    @(negedge clk); chk("cold_req", {31'b0, ic_mem_req}, 1); chk("cold_addr", ic_mem_addr, 0);
    tick(); mc_rdy = 1; mc_inst = 32'h0000_0513;
    @(negedge clk); chk("cold_fill", {31'b0, ic_fill_ready}, 1); chk("cold_fill_inst", ic_fill_inst, 32'h0000_0513);
    tick(); mc_rdy = 0; en = 1; pc = 32'h0;
    @(negedge clk); chk("cold_hit", {31'b0, icache_ready}, 1); chk("cold_hit_inst", icache_inst, 32'h0000_0513);
    tick(); en = 0;

    // conflict at index 2
    fill(32'h4, 32'hAAAA_0004);
    fill(32'h84, 32'hBBBB_0084);
    en = 1; pc = 32'h4;
    @(negedge clk); chk("conf_miss", {31'b0, icache_ready}, 0);
    tick(); en = 0;
    @(negedge clk); chk("conf_req", {31'b0, ic_mem_req}, 1); chk("conf_addr", ic_mem_addr, 32'h4);
    tick(); mc_rdy = 1; mc_inst = 32'hAAAA_0004;
    tick(); mc_rdy = 0;

    // halfword entries are independent
    fill(32'h2, 32'hCCCC_0002);
    en = 1; pc = 32'h2;
    @(negedge clk); chk("hw_hit", {31'b0, icache_ready}, 1); chk("hw_inst", icache_inst, 32'hCCCC_0002);
    tick(); pc = 32'h0;
    @(negedge clk); chk("hw0_hit", {31'b0, icache_ready}, 1); chk("hw0_inst", icache_inst, 32'h0000_0513);
    tick(); en = 0;

    // flush in WAIT, response three cycles later
    en = 1; pc = 32'h1000; tick();
    en = 0; flush = 1; tick();
    flush = 0; tick(); tick();
    mc_rdy = 1; mc_inst = 32'hDDDD_1000;
    @(negedge clk); chk("drain_fill", {31'b0, ic_fill_ready}, 0);
    tick(); mc_rdy = 0; en = 1; pc = 32'h1000;
    @(negedge clk); chk("drain_req", {31'b0, ic_mem_req}, 0);
    chk("drain_hit", {31'b0, icache_ready}, 1); chk("drain_inst", icache_inst, 32'hDDDD_1000);
    tick(); en = 0;

    // simultaneous flush and response
    en = 1; pc = 32'h2000; tick();
    en = 0; flush = 1; mc_rdy = 1; mc_inst = 32'hEEEE_2000;
    @(negedge clk); chk("sim_fill", {31'b0, ic_fill_ready}, 0);
    tick(); flush = 0; mc_rdy = 0; en = 1; pc = 32'h2000;
    @(negedge clk); chk("sim_req", {31'b0, ic_mem_req}, 0);
    chk("sim_hit", {31'b0, icache_ready}, 1); chk("sim_inst", icache_inst, 32'hEEEE_2000);
    tick();

    // rdy low blocks a hit
    rdy = 0;
    @(negedge clk); chk("rdy_low_ready", {31'b0, icache_ready}, 0);
    tick(); rdy = 1; en = 0;

    // async reset mid-refill
    en = 1; pc = 32'h3000; tick();
    en = 0;
    @(negedge clk); chk("wait_req", {31'b0, ic_mem_req}, 1);
    #2 rst = 0;
    #1 chk("async_rst_req", {31'b0, ic_mem_req}, 0);
    tick(); rst = 1; en = 1; pc = 32'h2000;
    @(negedge clk); chk("post_rst_miss", {31'b0, icache_ready}, 0);
    tick(); en = 0;
    @(negedge clk); chk("post_rst_req", {31'b0, ic_mem_req}, 1); chk("post_rst_addr", ic_mem_addr, 32'h2000);
    tick(); mc_rdy = 1; mc_inst = 32'hFFFF_2000;
    tick(); mc_rdy = 0;

    // random traffic
    repeat (3000) begin
      rst     = ($urandom_range(0, 499) != 0);
      rdy     = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 4) != 0);
      pc      = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 1));
      mc_rdy  = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      mc_inst = busy ? ((maddr * 32'h9E37_79B1) ^ 32'h0000_5A5A) : $urandom;
      tick();
    end
    rst = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
